mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single processor–memory port between the instruction cache controller and the data cache controller. Each cycle it forwards at most one request to memory and returns the memory's accept tag to the winning requester. It records which requester owns each outstanding load tag, so completion data reaches only the requester that issued the load. It sits between the two cache controllers and the memory module, and both controllers keep their existing retry-on-zero-response behaviour unchanged.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles the I-side may lose arbitration before it is forced to win; legal range 1–15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `proc2Imem_command` in 2: I-side command. BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
- `proc2Imem_addr` in 64: I-side address.
- `Imem2proc_response` out 4: I-side accept tag; 0 means rejected, retry.
- `Imem2proc_data` out 64: completion data.
- `Imem2proc_tag` out 4: I-side completion tag; 0 means none.
- `proc2Dmem_command` in 2: D-side command.
- `proc2Dmem_addr` in 64: D-side address.
- `proc2Dmem_data` in 64: D-side store data.
- `Dmem2proc_response` out 4, `Dmem2proc_data` out 64, `Dmem2proc_tag` out 4: D-side equivalents of the I-side outputs.
- `proc2mem_command` out 2, `proc2mem_addr` out 64, `proc2mem_data` out 64: to memory.
- `mem2proc_response` in 4, `mem2proc_data` in 64, `mem2proc_tag` in 4: from memory.
- `outstanding_count` out 4: registered count of valid owner entries.
- `tag_error` out 1: registered, sticky. Set when memory returns a completion tag with no owner.

## Operation
**Grant (combinational, every cycle)**
- A side is requesting when its command is not BUS_NONE.
- If only one side is requesting, that side wins.
- If both are requesting, D wins, unless `starve_cnt` is at least `STARVE_LIMIT`; then I wins.
- The winner's command and address are forwarded to memory. `proc2mem_data` is always `proc2Dmem_data`.
- If nobody is requesting, `proc2mem_command` is BUS_NONE.
- The winner's response output equals `mem2proc_response`. The loser's response output is 0.

**Starvation counter `starve_cnt` (4-bit)**
- Increments, saturating at 15, when I is requesting and loses.
- Clears when I wins or I is not requesting.

**Owner table: 15 entries, indexed by tag 1..15**
- Each entry holds a valid bit and an owner bit (0 = I, 1 = D).
- Set: when a LOAD is forwarded and `mem2proc_response` is nonzero, set valid and owner for that tag.
- Stores are never recorded.
- Completion: when `mem2proc_tag` is nonzero and its entry is valid:
  - drive that tag on the owner's tag output and 0 on the other side;
  - clear the entry.
- When `mem2proc_tag` is nonzero and its entry is not valid:
  - drive 0 on both tag outputs;
  - set `tag_error`.
- Both data outputs always carry `mem2proc_data`; the tag outputs act as qualifiers.
- If the same cycle completes tag T and accepts a new load with tag T, the set takes precedence and the entry ends valid with the new owner.
- `outstanding_count` equals the number of valid entries after each edge (popcount of the next-state valid bits).

## Timing
- Request path is zero latency: command in, response out in the same cycle.
- Completion routing is combinational in the same cycle as `mem2proc_tag`.
- Owner entries and `starve_cnt` update on the rising edge. A load accepted in cycle N is routable from cycle N+1.
- Reset, asynchronous and effective immediately:
  - all valid bits 0, `starve_cnt` 0, `outstanding_count` 0, `tag_error` 0;
  - combinational outputs follow their inputs, with tag outputs 0 because no entries are valid.
- Reset mid-flight discards all ownership. Later completions for pre-reset tags raise `tag_error` and are delivered to neither side.
- `tag_error` clears only on reset.

## Test plan
- **I-only load.** I issues LOAD at 0x1000 and memory responds 3. Required:
  - `proc2mem_addr` is 0x1000 and `Imem2proc_response` is 3;
  - `outstanding_count` is 1 next cycle;
  - a later `mem2proc_tag`=3 with data 0xDEAD gives `Imem2proc_tag`=3 and `Dmem2proc_tag`=0, and the count returns to 0.
- **Simultaneous requests, STARVE_LIMIT=4.** Both sides issue LOAD. Required: D is forwarded and `Imem2proc_response`=0. Both sides hold their LOADs for cycles 0..4 and memory always responds nonzero; required: D wins cycles 0–3 and I wins cycle 4.
- **D store.** D issues STORE and memory responds 5. Required: `Dmem2proc_response`=5 and `outstanding_count` unchanged.
- **Unowned completion.** With the table empty, memory drives `mem2proc_tag`=7. Required: both tag outputs are 0 and `tag_error`=1 next cycle, staying set.
- **Same-tag reuse.** An I load owns tag 2. In one cycle, tag 2 completes and a D load is accepted with response 2. Required: `Imem2proc_tag`=2 that cycle, and a later completion of tag 2 is routed to D.
- **Reset mid-flight.** Assert reset asynchronously, between clock edges, with 3 loads outstanding. Required: `outstanding_count`=0 immediately. After release, a completion of an old tag sets `tag_error`.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the I-cache and D-cache controllers.
// Tracks load-tag ownership so completions reach only the issuing side.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Imem_command,
  input  logic [63:0] proc2Imem_addr,
  output logic [3:0]  Imem2proc_response,
  output logic [63:0] Imem2proc_data,
  output logic [3:0]  Imem2proc_tag,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [63:0] proc2Dmem_addr,
  input  logic [63:0] proc2Dmem_data,
  output logic [3:0]  Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [3:0]  outstanding_count,
  output logic        tag_error
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic        i_req, d_req, i_win, d_win;
  logic        comp_hit, comp_own, load_acc;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // Grant: D has priority unless I has starved for LIMIT cycles
  always_comb begin
    i_req = (proc2Imem_command != BUS_NONE);
    d_req = (proc2Dmem_command != BUS_NONE);
    i_win = i_req && (!d_req || (starve_q >= LIMIT));
    d_win = d_req && !i_win;
  end

  // Forward the winner's request and steer the accept tag back to it
  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = proc2Dmem_addr;
    Imem2proc_response = 4'd0;
    Dmem2proc_response = 4'd0;
    unique case (1'b1)
      i_win: begin
        proc2mem_command   = proc2Imem_command;
        proc2mem_addr      = proc2Imem_addr;
        Imem2proc_response = mem2proc_response;
      end
      d_win: begin
        proc2mem_command   = proc2Dmem_command;
        proc2mem_addr      = proc2Dmem_addr;
        Dmem2proc_response = mem2proc_response;
      end
      default: ;
    endcase
  end

  assign proc2mem_data  = proc2Dmem_data;
  assign Imem2proc_data = mem2proc_data;
  assign Dmem2proc_data = mem2proc_data;

  // Route a completion tag to whichever side owns it
  always_comb begin
    comp_hit      = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    comp_own      = owner_q[mem2proc_tag];
    Imem2proc_tag = (comp_hit && !comp_own) ? mem2proc_tag : 4'd0;
    Dmem2proc_tag = (comp_hit &&  comp_own) ? mem2proc_tag : 4'd0;
  end

  // Next owner table: completion clears, a new accept on the same tag wins
  always_comb begin
    valid_d  = valid_q;
    owner_d  = owner_q;
    load_acc = (proc2mem_command == BUS_LOAD) &&
               (mem2proc_response != 4'd0);
    if (comp_hit) begin
      valid_d[mem2proc_tag] = 1'b0;
    end
    if (load_acc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = d_win;
    end
    valid_d[0] = 1'b0;
    owner_d[0] = 1'b0;
    cnt_d = 4'd0;
    for (int k = 1; k < 16; k++) begin
      cnt_d = cnt_d + {3'd0, valid_d[k]};
    end
    err_d = err_q ||
            ((mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag]);
  end

  // Starvation count of consecutive I-side losses, saturating
  always_comb begin
    starve_d = 4'd0;
    if (i_req && !i_win) begin
      starve_d = (starve_q == 4'hf) ? 4'hf : starve_q + 4'd1;
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      owner_q  <= '0;
      starve_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign outstanding_count = cnt_q;
  assign tag_error         = err_q;

endmodule
